bp_be_issue_queue_ctrl: RTL and testbench
=========================================

Name: bp_be_issue_queue_ctrl

Overview:
Sequencer for the backend issue queue. Turns pipeline events into the queue's per-cycle control strobes: read, dequeue/commit, roll, clear, inject and suppress. These are the clr/deq/roll/inject/suppress/read inputs of the issue queue. It tracks the number of issued-but-uncommitted instructions. It orders redirect, flush, interrupt injection and fence drain so that at most one pointer-restoring operation happens per cycle. It sits in bp_be_checker between the issue queue and the scheduler/commit logic.

Parameters:
compressed_support_p, 1, pointers count half-words; a 32-bit instruction advances by 2 (skip).
inflight_max_p, 8, maximum issued-but-uncommitted entries; equals the queue depth (fe_queue_fifo_els_p).

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous, active-low reset
issue_v_i  in  1  queue holds a valid issue packet
issue_compressed_i  in  1  head instruction is 16-bit
dispatch_ready_i  in  1  scheduler accepts the issue packet this cycle
commit_v_i  in  1  oldest issued instruction commits
commit_compressed_i  in  1  committing instruction is 16-bit
flush_v_i  in  1  squash all uncommitted instructions (roll back to checkpoint)
redirect_v_i  in  1  discard entire queue contents
interrupt_v_i  in  1  request to inject an interrupt op
inject_yumi_i  in  1  downstream consumed the injected op
fence_v_i  in  1  drain request: stop issuing until inflight is 0
read_v_o  out  1  advance read pointer
read_skip_o  out  1  read advances by 2 half-words
deq_v_o  out  1  advance checkpoint pointer
deq_skip_o  out  1  dequeue advances by 2 half-words
roll_v_o  out  1  restore read pointer to checkpoint
clr_v_o  out  1  clear all pointers
inject_v_o  out  1  injection in progress; masks issue
suppress_v_o  out  1  block enqueue and issue
inflight_o  out  $clog2(inflight_max_p+1)  uncommitted count
idle_o  out  1  state is e_run, inflight_o==0, no strobe active

Behaviour:
- Reset (reset_n_i==0 at a clock edge): state <= e_clear and inflight <= 0. While reset is asserted, every output is 0 except suppress_v_o=1.
- First cycle after reset: state e_clear, so clr_v_o=1 for exactly one cycle. The next state is e_run.
- States: e_run, e_clear, e_roll, e_inject, e_drain. Next-state priority, evaluated in every state: redirect > flush > interrupt > fence.
  - redirect_v_i goes to e_clear.
  - flush_v_i goes to e_roll.
  - interrupt_v_i goes to e_inject, from e_run or e_drain only.
  - fence_v_i goes to e_drain, from e_run only.
- e_run:
  - read_v_o = issue_v_i & dispatch_ready_i & (inflight < inflight_max_p) & no event input asserted this cycle.
  - read_skip_o = read_v_o & compressed_support_p & ~issue_compressed_i.
- e_clear: clr_v_o=1, suppress_v_o=1, read_v_o=0, deq_v_o=0. inflight <= 0. Return to e_run unless another event is pending.
- e_roll: roll_v_o=1 for one cycle, read_v_o=0. A commit in this cycle still drives deq_v_o, because the queue adds deq to the roll. inflight <= 0. Next state e_run.
- e_inject: inject_v_o=1 and suppress_v_o=1, held until inject_yumi_i. The cycle in which inject_yumi_i is seen is the last inject_v_o cycle; next state e_run. A redirect or flush preempts the injection.
- e_drain: suppress_v_o=1, read_v_o=0. Exit to e_run on the cycle after inflight_o==0.
- Dequeue, in all states except e_clear:
  - deq_v_o = commit_v_i.
  - deq_skip_o = deq_v_o & compressed_support_p & ~commit_compressed_i.
- With compressed_support_p=0, both skip outputs are tied to 0.
- inflight update, in order:
  - +1 on read_v_o, -1 on deq_v_o; unchanged when both occur.
  - Forced to 0 in e_clear and e_roll.
  - Saturates at 0 and at inflight_max_p. A commit at 0 is ignored and fires an assertion.
- Simultaneous redirect and flush: redirect wins and the flush is dropped (the clear subsumes the roll).
- A reset asserted mid-injection or mid-drain abandons it; after reset there is no pending state.

Decomposition:
- bp_be_pkg gets bp_be_issue_ctrl_state_e (e_run, e_clear, e_roll, e_inject, e_drain).
- The inflight counter is a natural sub-module: bsg_counter_up_down with a clear override, wrapped in bp_be_inflight_counter.
- Everything else (state register, next-state logic, output decode) stays in this module.

Test Plan:
1. Reset release with no events -> cycle 1: clr_v_o=1 and suppress_v_o=1; cycle 2: idle_o=1, all strobes 0.
2. Eight back-to-back 32-bit issues with dispatch_ready_i=1 and inflight_max_p=8 -> read_v_o=1 and read_skip_o=1 for 8 cycles; then read_v_o=0 with inflight_o=8; one commit reopens issue.
3. inflight=3, flush_v_i and commit_v_i in the same cycle -> next cycle roll_v_o=1 and deq_v_o reflects that cycle's commit input; inflight_o=0 afterwards.
4. redirect_v_i and flush_v_i together -> exactly one clr_v_o pulse, roll_v_o never asserted.
5. fence_v_i with inflight=2, commits on cycles 3 and 5 -> suppress_v_o=1 through the cycle after inflight reaches 0, then read_v_o resumes.
6. interrupt_v_i, inject_yumi_i after 4 cycles -> inject_v_o=1 for 4 cycles with read_v_o=0; a 16-bit commit mid-injection gives deq_v_o=1, deq_skip_o=0.

Source files
------------

// File: rtl/bp_be_issue_queue_ctrl_pkg.sv
// Shared types for the backend issue queue control sequencer.
//   bp_be_issue_ctrl_state_e : sequencer states
//   state_suppresses()       : states that block enqueue and issue
package bp_be_issue_queue_ctrl_pkg;

  typedef enum logic [2:0] {
    e_run    = 3'd0,
    e_clear  = 3'd1,
    e_roll   = 3'd2,
    e_inject = 3'd3,
    e_drain  = 3'd4
  } bp_be_issue_ctrl_state_e;

  function automatic logic state_suppresses(bp_be_issue_ctrl_state_e s);
    return (s == e_clear) || (s == e_inject) || (s == e_drain);
  endfunction

endpackage

// File: rtl/bp_be_issue_queue_ctrl_if.sv
// Pipeline-event and queue-strobe bundle of the issue queue sequencer.
// Directions in the signal names are as seen by the sequencer (slave).
//   inputs : issue_v_i, issue_compressed_i, dispatch_ready_i, commit_v_i,
//            commit_compressed_i, flush_v_i, redirect_v_i, interrupt_v_i,
//            inject_yumi_i, fence_v_i
//   outputs: read_v_o, read_skip_o, deq_v_o, deq_skip_o, roll_v_o, clr_v_o,
//            inject_v_o, suppress_v_o
// Handshake: an issue packet transfers in a cycle where issue_v_i and
// dispatch_ready_i are both high and read_v_o is high; inject_v_o is held
// until the cycle in which inject_yumi_i is seen, which is its last cycle.
interface bp_be_issue_queue_ctrl_if;

  logic issue_v_i;
  logic issue_compressed_i;
  logic dispatch_ready_i;
  logic commit_v_i;
  logic commit_compressed_i;
  logic flush_v_i;
  logic redirect_v_i;
  logic interrupt_v_i;
  logic inject_yumi_i;
  logic fence_v_i;

  logic read_v_o;
  logic read_skip_o;
  logic deq_v_o;
  logic deq_skip_o;
  logic roll_v_o;
  logic clr_v_o;
  logic inject_v_o;
  logic suppress_v_o;

  modport master (
    output issue_v_i, issue_compressed_i, dispatch_ready_i, commit_v_i,
           commit_compressed_i, flush_v_i, redirect_v_i, interrupt_v_i,
           inject_yumi_i, fence_v_i,
    input  read_v_o, read_skip_o, deq_v_o, deq_skip_o, roll_v_o, clr_v_o,
           inject_v_o, suppress_v_o
  );

  modport slave (
    input  issue_v_i, issue_compressed_i, dispatch_ready_i, commit_v_i,
           commit_compressed_i, flush_v_i, redirect_v_i, interrupt_v_i,
           inject_yumi_i, fence_v_i,
    output read_v_o, read_skip_o, deq_v_o, deq_skip_o, roll_v_o, clr_v_o,
           inject_v_o, suppress_v_o
  );

endinterface

// File: rtl/bp_be_issue_queue_ctrl_inflight_counter.sv
// bp_be_inflight_counter: saturating up/down count of issued-but-uncommitted
// instructions, with a synchronous clear that overrides up/down.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   clear_i          : force count to 0 next cycle
//   up_i / down_i    : +1 / -1 (cancel when both)
//   count_o          : current count, 0..max_val_p
module bp_be_inflight_counter #(
  parameter int unsigned max_val_p = 8,
  parameter int unsigned width_p   = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (up_i && !down_i && (count_q != max_lp)) begin
      count_d = count_q + 1'b1;
    end else if (down_i && !up_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

  // A commit with nothing in flight means the commit logic and the queue
  // have lost sync; the saturation above hides it, so flag it here.
  commit_at_zero_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(down_i && !clear_i && (count_q == '0)));

endmodule

// File: rtl/bp_be_issue_queue_ctrl.sv
// bp_be_issue_queue_ctrl: turns pipeline events into the issue queue's
// per-cycle read/deq/roll/clr/inject/suppress strobes and tracks the number
// of issued-but-uncommitted instructions. Only one pointer-restoring
// operation (clear or roll) is ever in effect per cycle.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   q_if             : event inputs and queue strobes (slave side)
//   inflight_o       : uncommitted instruction count
//   idle_o           : running, nothing in flight, no strobe active
//   state_o          : current sequencer state (debug)
module bp_be_issue_queue_ctrl
  import bp_be_issue_queue_ctrl_pkg::*;
#(
  parameter int unsigned compressed_support_p = 1,
  parameter int unsigned inflight_max_p       = 8,
  localparam int unsigned inflight_width_lp   = $clog2(inflight_max_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  bp_be_issue_queue_ctrl_if.slave      q_if,
  output logic [inflight_width_lp-1:0] inflight_o,
  output logic                         idle_o,
  output bp_be_issue_ctrl_state_e      state_o
);

  localparam logic [inflight_width_lp-1:0] inflight_max_lp =
    inflight_width_lp'(inflight_max_p);
  localparam logic compressed_lp = (compressed_support_p != 0);

  bp_be_issue_ctrl_state_e state_q, state_d;
  logic [inflight_width_lp-1:0] inflight_q;
  logic event_v;
  logic read_v, deq_v, roll_v, clr_v, inject_v, suppress_v;
  logic counter_clear;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_clear;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: per-state default first, then the event priority
  // redirect > flush > interrupt > fence overrides it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_run, e_clear, e_roll: state_d = e_run;
      e_inject:               if (q_if.inject_yumi_i) state_d = e_run;
      e_drain:                if (inflight_q == '0) state_d = e_run;
      default:                state_d = e_run;
    endcase

    // A simultaneous flush is dropped: the clear subsumes the roll.
    if (q_if.redirect_v_i) begin
      state_d = e_clear;
    end else if (q_if.flush_v_i) begin
      state_d = e_roll;
    end else if (q_if.interrupt_v_i && ((state_q == e_run) || (state_q == e_drain))) begin
      state_d = e_inject;
    end else if (q_if.fence_v_i && (state_q == e_run)) begin
      state_d = e_drain;
    end
  end

  // Output decode. Reset masks every strobe and holds suppress high so the
  // queue cannot be written while the sequencer is not yet in a known state.
  always_comb begin
    event_v    = q_if.redirect_v_i | q_if.flush_v_i | q_if.interrupt_v_i | q_if.fence_v_i;
    read_v     = reset_n_i && (state_q == e_run) && q_if.issue_v_i
                 && q_if.dispatch_ready_i && (inflight_q < inflight_max_lp) && !event_v;
    // The roll state still dequeues: the queue folds deq into the restore.
    deq_v      = reset_n_i && (state_q != e_clear) && q_if.commit_v_i;
    roll_v     = reset_n_i && (state_q == e_roll);
    clr_v      = reset_n_i && (state_q == e_clear);
    inject_v   = reset_n_i && (state_q == e_inject);
    suppress_v = !reset_n_i || state_suppresses(state_q);

    q_if.read_v_o     = read_v;
    q_if.read_skip_o  = read_v & compressed_lp & ~q_if.issue_compressed_i;
    q_if.deq_v_o      = deq_v;
    q_if.deq_skip_o   = deq_v & compressed_lp & ~q_if.commit_compressed_i;
    q_if.roll_v_o     = roll_v;
    q_if.clr_v_o      = clr_v;
    q_if.inject_v_o   = inject_v;
    q_if.suppress_v_o = suppress_v;

    inflight_o = reset_n_i ? inflight_q : '0;
    idle_o     = reset_n_i && (state_q == e_run) && (inflight_q == '0)
                 && !(read_v | deq_v | roll_v | clr_v | inject_v | suppress_v);
    state_o    = state_q;
  end

  // Clear and roll both discard every uncommitted instruction.
  assign counter_clear = (state_q == e_clear) || (state_q == e_roll);

  bp_be_inflight_counter #(
    .max_val_p (inflight_max_p),
    .width_p   (inflight_width_lp)
  ) inflight_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (counter_clear),
    .up_i      (read_v),
    .down_i    (deq_v),
    .count_o   (inflight_q)
  );

endmodule

// File: tb/tb_bp_be_issue_queue_ctrl.sv
module tb_bp_be_issue_queue_ctrl;
  import bp_be_issue_queue_ctrl_pkg::*;

  localparam int MAX = 8;
  localparam int C   = 1;
  localparam int W   = 4;
  localparam int M_RUN = 0, M_CLEAR = 1, M_ROLL = 2, M_INJECT = 3, M_DRAIN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [W-1:0] inflight;
  logic idle;
  bp_be_issue_ctrl_state_e state;

  bp_be_issue_queue_ctrl_if q_if();

  bp_be_issue_queue_ctrl #(
    .compressed_support_p (C),
    .inflight_max_p       (MAX)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .q_if       (q_if),
    .inflight_o (inflight),
    .idle_o     (idle),
    .state_o    (state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // Mode of the sequencer and number of uncommitted instructions, stepped
  // once per clock from the same inputs the DUT sees.
  int m_mode = M_CLEAR;
  int m_infl = 0;

  // Output vector: {read, read_skip, deq, deq_skip, roll, clr, inject, suppress, idle, inflight[3:0]}
  function automatic logic [12:0] model_out();
    logic rd, rs, dq, ds, rl, cl, inj, sup, idl, ev;
    logic [W-1:0] inf;
    if (!reset_n) begin
      return {7'b0, 1'b1, 1'b0, 4'b0};
    end
    ev  = q_if.redirect_v_i | q_if.flush_v_i | q_if.interrupt_v_i | q_if.fence_v_i;
    rd  = (m_mode == M_RUN) && q_if.issue_v_i && q_if.dispatch_ready_i && (m_infl < MAX) && !ev;
    rs  = rd && (C != 0) && !q_if.issue_compressed_i;
    dq  = (m_mode != M_CLEAR) && q_if.commit_v_i;
    ds  = dq && (C != 0) && !q_if.commit_compressed_i;
    rl  = (m_mode == M_ROLL);
    cl  = (m_mode == M_CLEAR);
    inj = (m_mode == M_INJECT);
    sup = (m_mode == M_CLEAR) || (m_mode == M_INJECT) || (m_mode == M_DRAIN);
    idl = (m_mode == M_RUN) && (m_infl == 0) && !(rd | dq | rl | cl | inj | sup);
    inf = W'(m_infl);
    return {rd, rs, dq, ds, rl, cl, inj, sup, idl, inf};
  endfunction

  function automatic logic [12:0] dut_out();
    return {q_if.read_v_o, q_if.read_skip_o, q_if.deq_v_o, q_if.deq_skip_o,
            q_if.roll_v_o, q_if.clr_v_o, q_if.inject_v_o, q_if.suppress_v_o,
            idle, inflight};
  endfunction

  task automatic model_step();
    logic [12:0] e;
    int nm, ni;
    if (!reset_n) begin
      m_mode = M_CLEAR;
      m_infl = 0;
      return;
    end
    e = model_out();
    if (m_mode == M_CLEAR || m_mode == M_ROLL) ni = 0;
    else begin
      ni = m_infl + (e[12] ? 1 : 0) - (e[10] ? 1 : 0);
      if (ni < 0) ni = 0;
      if (ni > MAX) ni = MAX;
    end
    case (m_mode)
      M_INJECT: nm = q_if.inject_yumi_i ? M_RUN : M_INJECT;
      M_DRAIN:  nm = (m_infl == 0) ? M_RUN : M_DRAIN;
      default:  nm = M_RUN;
    endcase
    if (q_if.redirect_v_i) nm = M_CLEAR;
    else if (q_if.flush_v_i) nm = M_ROLL;
    else if (q_if.interrupt_v_i && (m_mode == M_RUN || m_mode == M_DRAIN)) nm = M_INJECT;
    else if (q_if.fence_v_i && m_mode == M_RUN) nm = M_DRAIN;
    m_mode = nm;
    m_infl = ni;
  endtask

  // ---------------- driver tasks ----------------
  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    q_if.issue_v_i = 0; q_if.issue_compressed_i = 0; q_if.dispatch_ready_i = 0;
    q_if.commit_v_i = 0; q_if.commit_compressed_i = 0; q_if.flush_v_i = 0;
    q_if.redirect_v_i = 0; q_if.interrupt_v_i = 0; q_if.inject_yumi_i = 0;
    q_if.fence_v_i = 0;
  endtask

  task automatic go_clean();
    clear_inputs();
    q_if.redirect_v_i = 1;
    @(negedge clk); advance();
    q_if.redirect_v_i = 0;
    @(negedge clk); advance();
  endtask

  task automatic issue_n(input int n);
    q_if.issue_v_i = 1; q_if.dispatch_ready_i = 1;
    for (int i = 0; i < n; i++) begin
      q_if.issue_compressed_i = 1'($urandom_range(0, 1));
      @(negedge clk); advance();
    end
    clear_inputs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] exp, obs;
    reset_n = 0;
    for (int i = 0; i < 3; i++) begin
      q_if.issue_v_i = 1'($urandom_range(0, 1)); q_if.dispatch_ready_i = 1;
      q_if.commit_v_i = 1'($urandom_range(0, 1));
      q_if.interrupt_v_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp = model_out(); obs = dut_out(); n_checks++;
      if (obs !== exp) $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, obs, exp);
      else n_pass++;
      advance();
    end
    clear_inputs();
    reset_n = 1;
    @(negedge clk);
    exp = model_out(); obs = dut_out(); n_checks++;
    if (obs !== exp) $display("FAIL reset_first_cycle got=%b want=%b", obs, exp);
    else n_pass++;
    n_checks++;
    if (q_if.clr_v_o !== 1'b1 || q_if.suppress_v_o !== 1'b1)
      $display("FAIL reset_clr_pulse got clr=%b sup=%b want clr=1 sup=1", q_if.clr_v_o, q_if.suppress_v_o);
    else n_pass++;
    advance();
    @(negedge clk);
    obs = dut_out(); n_checks++;
    if (idle !== 1'b1 || obs[12:5] !== 8'b0 || inflight !== 4'd0 || state !== e_run)
      $display("FAIL reset_idle got=%b state=%0d want idle=1 strobes=0 state=%0d", obs, state, e_run);
    else n_pass++;
    advance();
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp, obs;
    int reads = 0;
    go_clean();
    q_if.issue_v_i = 1; q_if.issue_compressed_i = 0; q_if.dispatch_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp = model_out(); obs = dut_out(); n_checks++;
      if (obs !== exp) $display("FAIL b2b_issue cyc=%0d got=%b want=%b", i, obs, exp);
      else n_pass++;
      if (q_if.read_v_o === 1'b1 && q_if.read_skip_o === 1'b1) reads++;
      advance();
    end
    n_checks++;
    if (reads != 8) $display("FAIL b2b_read_count got=%0d want=8", reads);
    else n_pass++;
    n_checks++;
    if (inflight !== 4'd8 || q_if.read_v_o !== 1'b0)
      $display("FAIL b2b_full got inflight=%0d read=%b want inflight=8 read=0", inflight, q_if.read_v_o);
    else n_pass++;
    q_if.commit_v_i = 1;
    @(negedge clk);
    exp = model_out(); obs = dut_out(); n_checks++;
    if (obs !== exp) $display("FAIL b2b_commit got=%b want=%b", obs, exp);
    else n_pass++;
    advance();
    q_if.commit_v_i = 0;
    @(negedge clk);
    n_checks++;
    if (q_if.read_v_o !== 1'b1 || inflight !== 4'd7)
      $display("FAIL b2b_reopen got read=%b inflight=%0d want read=1 inflight=7", q_if.read_v_o, inflight);
    else n_pass++;
    advance();
    clear_inputs();
  endtask

  task automatic test_flush_commit();
    logic [12:0] exp, obs;
    go_clean();
    issue_n(3);
    q_if.flush_v_i = 1; q_if.commit_v_i = 1;
    @(negedge clk);
    exp = model_out(); obs = dut_out(); n_checks++;
    if (obs !== exp) $display("FAIL flush_cycle got=%b want=%b", obs, exp);
    else n_pass++;
    advance();
    q_if.flush_v_i = 0; q_if.commit_v_i = 1; q_if.commit_compressed_i = 1;
    @(negedge clk);
    exp = model_out(); obs = dut_out(); n_checks++;
    if (obs !== exp) $display("FAIL roll_cycle got=%b want=%b", obs, exp);
    else n_pass++;
    n_checks++;
    if (q_if.roll_v_o !== 1'b1 || q_if.deq_v_o !== 1'b1 || q_if.deq_skip_o !== 1'b0 || q_if.read_v_o !== 1'b0)
      $display("FAIL roll_with_deq got roll=%b deq=%b skip=%b read=%b want 1 1 0 0",
               q_if.roll_v_o, q_if.deq_v_o, q_if.deq_skip_o, q_if.read_v_o);
    else n_pass++;
    advance();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (inflight !== 4'd0 || state !== e_run)
      $display("FAIL roll_after got inflight=%0d state=%0d want 0 %0d", inflight, state, e_run);
    else n_pass++;
    advance();
  endtask

  task automatic test_redirect_flush();
    logic [12:0] exp, obs;
    int clrs = 0, rolls = 0;
    go_clean();
    issue_n(2);
    q_if.redirect_v_i = 1; q_if.flush_v_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp = model_out(); obs = dut_out(); n_checks++;
      if (obs !== exp) $display("FAIL redirect_flush cyc=%0d got=%b want=%b", i, obs, exp);
      else n_pass++;
      if (q_if.clr_v_o === 1'b1) clrs++;
      if (q_if.roll_v_o === 1'b1) rolls++;
      advance();
      clear_inputs();
    end
    n_checks++;
    if (clrs != 1 || rolls != 0)
      $display("FAIL redirect_flush_pulses got clr=%0d roll=%0d want clr=1 roll=0", clrs, rolls);
    else n_pass++;
  endtask

  task automatic test_fence();
    logic [12:0] exp, obs;
    int last_sup = -1, first_read = -1;
    go_clean();
    issue_n(2);
    q_if.issue_v_i = 1; q_if.dispatch_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      q_if.fence_v_i = (i == 0);
      q_if.commit_v_i = (i == 3 || i == 5);
      @(negedge clk);
      exp = model_out(); obs = dut_out(); n_checks++;
      if (obs !== exp) $display("FAIL fence cyc=%0d got=%b want=%b", i, obs, exp);
      else n_pass++;
      if (q_if.suppress_v_o === 1'b1) last_sup = i;
      if (q_if.read_v_o === 1'b1 && first_read < 0) first_read = i;
      advance();
    end
    clear_inputs();
    n_checks++;
    if (last_sup != 6 || first_read != 7)
      $display("FAIL fence_drain got last_sup=%0d first_read=%0d want 6 7", last_sup, first_read);
    else n_pass++;
  endtask

  task automatic test_inject();
    logic [12:0] exp, obs;
    int injs = 0, bad_reads = 0;
    go_clean();
    issue_n(1);
    q_if.issue_v_i = 1; q_if.dispatch_ready_i = 1;
    for (int i = 0; i < 7; i++) begin
      q_if.interrupt_v_i = (i == 0);
      q_if.commit_v_i = (i == 2); q_if.commit_compressed_i = (i == 2);
      q_if.inject_yumi_i = (i == 4);
      @(negedge clk);
      exp = model_out(); obs = dut_out(); n_checks++;
      if (obs !== exp) $display("FAIL inject cyc=%0d got=%b want=%b", i, obs, exp);
      else n_pass++;
      if (q_if.inject_v_o === 1'b1) begin
        injs++;
        if (q_if.read_v_o !== 1'b0) bad_reads++;
      end
      if (i == 2) begin
        n_checks++;
        if (q_if.deq_v_o !== 1'b1 || q_if.deq_skip_o !== 1'b0)
          $display("FAIL inject_deq got deq=%b skip=%b want 1 0", q_if.deq_v_o, q_if.deq_skip_o);
        else n_pass++;
      end
      advance();
    end
    clear_inputs();
    n_checks++;
    if (injs != 4 || bad_reads != 0)
      $display("FAIL inject_len got inject=%0d reads=%0d want 4 0", injs, bad_reads);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [12:0] exp, obs;
    int errs = 0;
    go_clean();
    for (int i = 0; i < 1500; i++) begin
      reset_n                  = ($urandom_range(0, 149) != 0);
      q_if.issue_v_i           = ($urandom_range(0, 3) != 0);
      q_if.issue_compressed_i  = 1'($urandom_range(0, 1));
      q_if.dispatch_ready_i    = ($urandom_range(0, 3) != 0);
      q_if.commit_v_i          = (m_infl > 0) && ($urandom_range(0, 1) != 0);
      q_if.commit_compressed_i = 1'($urandom_range(0, 1));
      q_if.redirect_v_i        = ($urandom_range(0, 39) == 0);
      q_if.flush_v_i           = ($urandom_range(0, 29) == 0);
      q_if.interrupt_v_i       = ($urandom_range(0, 24) == 0);
      q_if.fence_v_i           = ($urandom_range(0, 24) == 0);
      q_if.inject_yumi_i       = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      exp = model_out(); obs = dut_out(); n_checks++;
      if (obs !== exp) begin
        if (errs < 10) $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp);
        errs++;
      end else n_pass++;
      advance();
    end
    reset_n = 1;
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n = 0;
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_flush_commit();
    test_redirect_flush();
    test_fence();
    test_inject();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
